// File: rtl/multi_ctrl_sequencer.sv
// Three-stage enable sequencer (ctrl1 -> ctrl2 -> ctrl3) with per-step ack timeout and sticky fault.
// Define MCSM_FAULT_CODE_EN to add the fault_code output.
module multi_ctrl_sequencer #(
   parameter int TIMEOUT = 8,
   parameter int CNT_W   = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic in1,
   input  logic in2,
   input  logic in3,
   output logic ctrl1,
   output logic ctrl2,
   output logic ctrl3,
   output logic fault,
   output logic normal_start
`ifdef MCSM_FAULT_CODE_EN
   ,
   output logic [1:0] fault_code
`endif
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_S1   = 3'd1,
      ST_S2   = 3'd2,
      ST_S3   = 3'd3,
      ST_RUN  = 3'd4,
      ST_FLT  = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

   state_t           state_r;
   state_t           state_nxt_s;
   logic [CNT_W-1:0] cnt_r;
   logic [4:0]       outs_r;
   logic             timeout_s;

   // Output vector is {ctrl1, ctrl2, ctrl3, fault, normal_start}.
   function automatic logic [4:0] decode(input state_t s);
      case (s)
         ST_IDLE: decode = 5'b00000;
         ST_S1:   decode = 5'b10000;
         ST_S2:   decode = 5'b11000;
         ST_S3:   decode = 5'b11100;
         ST_RUN:  decode = 5'b11101;
         ST_FLT:  decode = 5'b00010;
         default: decode = 5'b00000;
      endcase
   endfunction

   assign timeout_s = (cnt_r == TO_LAST);

   // Next-state logic: start=0 beats ack loss, which beats advance, which beats timeout.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) state_nxt_s = ST_S1;
            else       state_nxt_s = ST_IDLE;
         end
         ST_S1: begin
            if (!start)         state_nxt_s = ST_IDLE;
            else if (in1)       state_nxt_s = ST_S2;
            else if (timeout_s) state_nxt_s = ST_FLT;
            else                state_nxt_s = ST_S1;
         end
         ST_S2: begin
            if (!start)         state_nxt_s = ST_IDLE;
            else if (!in1)      state_nxt_s = ST_FLT;
            else if (in2)       state_nxt_s = ST_S3;
            else if (timeout_s) state_nxt_s = ST_FLT;
            else                state_nxt_s = ST_S2;
         end
         ST_S3: begin
            if (!start)             state_nxt_s = ST_IDLE;
            else if (!in1 || !in2)  state_nxt_s = ST_FLT;
            else if (in3)           state_nxt_s = ST_RUN;
            else if (timeout_s)     state_nxt_s = ST_FLT;
            else                    state_nxt_s = ST_S3;
         end
         ST_RUN: begin
            if (!start)                   state_nxt_s = ST_IDLE;
            else if (!in1 || !in2 || !in3) state_nxt_s = ST_FLT;
            else                          state_nxt_s = ST_RUN;
         end
         ST_FLT:  state_nxt_s = ST_FLT;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State, step counter and outputs registered together so outputs track the state exactly.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         cnt_r   <= {CNT_W{1'b0}};
         outs_r  <= 5'b00000;
      end else begin
         state_r <= state_nxt_s;
         outs_r  <= decode(state_nxt_s);
         if (state_nxt_s != state_r)
            cnt_r <= {CNT_W{1'b0}};
         else if (state_r == ST_S1 || state_r == ST_S2 || state_r == ST_S3)
            cnt_r <= cnt_r + CNT_W'(1);
         else
            cnt_r <= {CNT_W{1'b0}};
      end
   end

   assign {ctrl1, ctrl2, ctrl3, fault, normal_start} = outs_r;

`ifdef MCSM_FAULT_CODE_EN
   logic [1:0] code_nxt_s;
   logic [1:0] code_r;

   // FAULT is only entered from S1..RUN, so the source state identifies the failing step.
   always_comb begin
      code_nxt_s = 2'b11;
      case (state_r)
         ST_S1:   code_nxt_s = 2'b01;
         ST_S2:   code_nxt_s = 2'b10;
         default: code_nxt_s = 2'b11;
      endcase
   end

   // Capture the code on FAULT entry; held until reset since FAULT never exits otherwise.
   always_ff @(posedge clk) begin
      if (rst)
         code_r <= 2'b00;
      else if (state_nxt_s == ST_FLT && state_r != ST_FLT)
         code_r <= code_nxt_s;
      else
         code_r <= code_r;
   end

   assign fault_code = code_r;
`endif

endmodule

// File: tb/tb_multi_ctrl_sequencer.sv
// Directed self-checking bench for multi_ctrl_sequencer (TIMEOUT=8).
module tb_multi_ctrl_sequencer;

   logic clk = 1'b0;
   logic rst, start, in1, in2, in3;
   logic ctrl1, ctrl2, ctrl3, fault, normal_start;
`ifdef MCSM_FAULT_CODE_EN
   logic [1:0] fault_code;
`endif

   int checks   = 0;
   int failures = 0;

   multi_ctrl_sequencer #(.TIMEOUT(8), .CNT_W(8)) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .in1(in1),
      .in2(in2),
      .in3(in3),
      .ctrl1(ctrl1),
      .ctrl2(ctrl2),
      .ctrl3(ctrl3),
      .fault(fault),
      .normal_start(normal_start)
`ifdef MCSM_FAULT_CODE_EN
      ,
      .fault_code(fault_code)
`endif
   );

   always #5 clk = ~clk;

   // {ctrl1, ctrl2, ctrl3, fault, normal_start}
   function automatic logic [4:0] outs();
      return {ctrl1, ctrl2, ctrl3, fault, normal_start};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; in1 = 1'b0; in2 = 1'b0; in3 = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; in1 = 1'b0; in2 = 1'b0; in3 = 1'b0;
      tick();
      tick();
      checks++;
      if (outs() !== 5'b00000) begin
         failures++;
         $display("FAIL reset_outs got=%b exp=%b", outs(), 5'b00000);
      end
`ifdef MCSM_FAULT_CODE_EN
      checks++;
      if (fault_code !== 2'b00) begin
         failures++;
         $display("FAIL reset_code got=%b exp=%b", fault_code, 2'b00);
      end
`endif
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (outs() !== 5'b00000) begin
            failures++;
            $display("FAIL idle_hold i=%0d got=%b exp=%b", i, outs(), 5'b00000);
         end
      end
   endtask

   // Leaves the DUT in RUN at cycle 12 with all acks high.
   task automatic test_nominal();
      logic [4:0] exp;
      do_reset();
      start = 1'b1;
      checks++;
      if (outs() !== 5'b00000) begin
         failures++;
         $display("FAIL nominal_c0 got=%b exp=%b", outs(), 5'b00000);
      end
      for (int cyc = 1; cyc <= 12; cyc++) begin
         tick();
         exp = {1'b1, cyc >= 4, cyc >= 7, 1'b0, cyc >= 10};
         checks++;
         if (outs() !== exp) begin
            failures++;
            $display("FAIL nominal cyc=%0d got=%b exp=%b", cyc, outs(), exp);
         end
         in1 = (cyc >= 3);
         in2 = (cyc >= 6);
         in3 = (cyc >= 9);
      end
   endtask

   task automatic test_run_loss();
      logic [4:0] exp;
      for (int cyc = 13; cyc <= 18; cyc++) begin
         tick();
         exp = (cyc < 18) ? 5'b11101 : 5'b00010;
         checks++;
         if (outs() !== exp) begin
            failures++;
            $display("FAIL run_loss cyc=%0d got=%b exp=%b", cyc, outs(), exp);
         end
         if (cyc == 17) in3 = 1'b0;
      end
      // FAULT must ignore start and acks.
      start = 1'b0; in3 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (i == 1) start = 1'b1;
         checks++;
         if (outs() !== 5'b00010) begin
            failures++;
            $display("FAIL fault_sticky i=%0d got=%b exp=%b", i, outs(), 5'b00010);
         end
      end
`ifdef MCSM_FAULT_CODE_EN
      checks++;
      if (fault_code !== 2'b11) begin
         failures++;
         $display("FAIL run_loss_code got=%b exp=%b", fault_code, 2'b11);
      end
`endif
      // Reset while faulted clears the fault.
      rst = 1'b1;
      tick();
      checks++;
      if (outs() !== 5'b00000) begin
         failures++;
         $display("FAIL fault_reset got=%b exp=%b", outs(), 5'b00000);
      end
`ifdef MCSM_FAULT_CODE_EN
      checks++;
      if (fault_code !== 2'b00) begin
         failures++;
         $display("FAIL fault_reset_code got=%b exp=%b", fault_code, 2'b00);
      end
`endif
      rst = 1'b0;
   endtask

   task automatic test_timeout();
      logic [4:0] exp;
      do_reset();
      start = 1'b1;
      for (int cyc = 1; cyc <= 13; cyc++) begin
         tick();
         exp = (cyc >= 12) ? 5'b00010 : (cyc >= 4) ? 5'b11000 : 5'b10000;
         checks++;
         if (outs() !== exp) begin
            failures++;
            $display("FAIL timeout_s2 cyc=%0d got=%b exp=%b", cyc, outs(), exp);
         end
         in1 = (cyc >= 3);
      end
`ifdef MCSM_FAULT_CODE_EN
      checks++;
      if (fault_code !== 2'b10) begin
         failures++;
         $display("FAIL timeout_s2_code got=%b exp=%b", fault_code, 2'b10);
      end
`endif
   endtask

   task automatic test_ack_loss_s2();
      logic [4:0] exp;
      do_reset();
      start = 1'b1;
      for (int cyc = 1; cyc <= 6; cyc++) begin
         tick();
         exp = (cyc == 6) ? 5'b00010 : (cyc >= 4) ? 5'b11000 : 5'b10000;
         checks++;
         if (outs() !== exp) begin
            failures++;
            $display("FAIL loss_s2 cyc=%0d got=%b exp=%b", cyc, outs(), exp);
         end
         in1 = (cyc >= 3 && cyc < 5);
      end
`ifdef MCSM_FAULT_CODE_EN
      checks++;
      if (fault_code !== 2'b10) begin
         failures++;
         $display("FAIL loss_s2_code got=%b exp=%b", fault_code, 2'b10);
      end
`endif
   endtask

   task automatic test_shutdown();
      logic [4:0] exp;
      do_reset();
      start = 1'b1;
      for (int cyc = 1; cyc <= 16; cyc++) begin
         tick();
         if (cyc == 13)      exp = 5'b10000;
         else if (cyc == 14) exp = 5'b11000;
         else if (cyc == 15) exp = 5'b11100;
         else if (cyc == 16) exp = 5'b11101;
         else if (cyc >= 11) exp = 5'b00000;
         else                exp = {1'b1, cyc >= 4, cyc >= 7, 1'b0, cyc >= 10};
         checks++;
         if (outs() !== exp) begin
            failures++;
            $display("FAIL shutdown cyc=%0d got=%b exp=%b", cyc, outs(), exp);
         end
         in1 = (cyc >= 3);
         in2 = (cyc >= 6);
         in3 = (cyc >= 9);
         start = !(cyc == 10 || cyc == 11);
      end
   endtask

   task automatic test_reset_mid();
      logic [4:0] exp;
      do_reset();
      start = 1'b1;
      for (int cyc = 1; cyc <= 9; cyc++) begin
         tick();
         if (cyc >= 8)      exp = 5'b10000;
         else if (cyc >= 6) exp = 5'b00000;
         else if (cyc >= 4) exp = 5'b11000;
         else               exp = 5'b10000;
         checks++;
         if (outs() !== exp) begin
            failures++;
            $display("FAIL reset_mid cyc=%0d got=%b exp=%b", cyc, outs(), exp);
         end
         in1 = (cyc >= 3 && cyc <= 4);
         rst = (cyc == 5 || cyc == 6);
      end
   endtask

   task automatic test_early_ack();
      logic [4:0] exp;
      do_reset();
      in2 = 1'b1;
      start = 1'b1;
      for (int cyc = 1; cyc <= 13; cyc++) begin
         tick();
         if (cyc == 13)     exp = 5'b00010;
         else if (cyc >= 5) exp = 5'b11100;
         else if (cyc == 4) exp = 5'b11000;
         else               exp = 5'b10000;
         checks++;
         if (outs() !== exp) begin
            failures++;
            $display("FAIL early_ack cyc=%0d got=%b exp=%b", cyc, outs(), exp);
         end
         in1 = (cyc >= 3);
      end
`ifdef MCSM_FAULT_CODE_EN
      checks++;
      if (fault_code !== 2'b11) begin
         failures++;
         $display("FAIL timeout_s3_code got=%b exp=%b", fault_code, 2'b11);
      end
`endif
   endtask

   task automatic test_boundary();
      logic [4:0] exp;
      // in1 on the last allowed cycle advances.
      do_reset();
      start = 1'b1;
      for (int cyc = 1; cyc <= 10; cyc++) begin
         tick();
         exp = (cyc >= 9) ? 5'b11000 : 5'b10000;
         checks++;
         if (outs() !== exp) begin
            failures++;
            $display("FAIL boundary_adv cyc=%0d got=%b exp=%b", cyc, outs(), exp);
         end
         in1 = (cyc >= 8);
      end
      // in1 never arrives: step-1 timeout.
      do_reset();
      start = 1'b1;
      for (int cyc = 1; cyc <= 10; cyc++) begin
         tick();
         exp = (cyc >= 9) ? 5'b00010 : 5'b10000;
         checks++;
         if (outs() !== exp) begin
            failures++;
            $display("FAIL timeout_s1 cyc=%0d got=%b exp=%b", cyc, outs(), exp);
         end
      end
`ifdef MCSM_FAULT_CODE_EN
      checks++;
      if (fault_code !== 2'b01) begin
         failures++;
         $display("FAIL timeout_s1_code got=%b exp=%b", fault_code, 2'b01);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_run_loss();
      test_timeout();
      test_ack_loss_s2();
      test_shutdown();
      test_reset_mid();
      test_early_ack();
      test_boundary();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multi_ctrl_sequencer.md
Name: multi_ctrl_sequencer

Overview:
- Power-up/enable sequencer that brings up three controlled subsystems in order: ctrl1, then ctrl2, then ctrl3.
- Each step waits for the matching acknowledge input (in1/in2/in3) before moving on.
- When all three are acknowledged, it asserts normal_start.
- A missing acknowledge (timeout), or the loss of an acknowledge already received, latches fault and shuts all controls off.

Parameters:
- TIMEOUT, 8: maximum cycles to wait for each acknowledge after its ctrl rises (valid range 1..255).
- CNT_W, 8: width of the per-step wait counter; must hold TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  level request to run the sequence; deassertion requests shutdown.
- in1  input  1  acknowledge/status from subsystem 1.
- in2  input  1  acknowledge/status from subsystem 2.
- in3  input  1  acknowledge/status from subsystem 3.
- ctrl1  output  1  enable for subsystem 1.
- ctrl2  output  1  enable for subsystem 2.
- ctrl3  output  1  enable for subsystem 3.
- fault  output  1  sticky fault flag.
- normal_start  output  1  high while all subsystems are up and healthy.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: state=IDLE, counter=0, all outputs 0.
- Outputs are a pure decode of the registered state (Moore, no input-to-output paths).
- State table (outputs):
  - IDLE: all outputs 0.
  - S1: ctrl1=1.
  - S2: ctrl1=1, ctrl2=1.
  - S3: ctrl1=1, ctrl2=1, ctrl3=1.
  - RUN: ctrl1..3=1, normal_start=1.
  - FAULT: fault=1, all ctrl and normal_start 0.
- Counter: cleared on every state change; increments each cycle spent in S1/S2/S3.
- IDLE: start=1 -> S1 on the next edge. The first ctrl1=1 cycle is the cycle after start is sampled.
- S1: in1=1 -> S2. Else, counter reaches TIMEOUT-1 -> FAULT.
- S2:
  - in1=0 -> FAULT.
  - else in2=1 -> S3.
  - else timeout -> FAULT.
- S3:
  - in1=0 or in2=0 -> FAULT.
  - else in3=1 -> RUN.
  - else timeout -> FAULT.
- RUN: any of in1/in2/in3 = 0 -> FAULT. normal_start stays high otherwise.
- start=0 in S1/S2/S3/RUN -> IDLE (clean shutdown, no fault). This takes priority over all other transitions in those states.
- Priority in S1..S3: start=0 > ack-loss fault > ack advance > timeout. An ack in the same cycle as the timeout advances.
- FAULT is sticky: it exits only on rst, ignoring start and the in inputs.
- Acks are sampled only in their own and later states. An early ack (e.g. in2 high during S1) is ignored until S2, where it advances immediately.
- Reset mid-operation (any state): next edge returns to IDLE with all outputs 0. If start is still 1, the sequence restarts from S1 one cycle after rst falls.
- No combinational loops; all state and counter registers update only on the rising clk edge.

Optional Feature:
- Macro: MCSM_FAULT_CODE_EN.
- When defined: adds output fault_code[1:0], captured on entry to FAULT.
  - 01: step-1 timeout.
  - 10: step-2 timeout or in1 loss in S2.
  - 11: step-3 timeout or ack loss in S3/RUN.
  - fault_code is 00 when not faulted and is cleared by rst.
- When undefined: the port is absent and behaviour is otherwise identical.

Test Plan:
- Nominal sequence: rst high 2 cycles, then low; start=1; bench drives each inN high 2 cycles after ctrlN rises.
  - Expect ctrl1 at cycle 1, ctrl2 at cycle 4, ctrl3 at cycle 7, normal_start at cycle 10.
  - fault stays 0 throughout.
- Ack loss in RUN: in3 drops 10 cycles after ctrl3 rises -> fault=1 and ctrl1..3=0 on the next edge; state holds until rst.
- Timeout: in2 never asserts with TIMEOUT=8 -> fault=1 exactly 8 cycles after ctrl2 rises.
  - With MCSM_FAULT_CODE_EN, fault_code=10.
- Shutdown: start dropped in RUN -> all outputs 0 next cycle, fault=0. start raised again -> sequence restarts at S1.
- Reset mid-sequence: rst pulsed 2 cycles while in S2 with start=1 -> outputs 0 during reset, ctrl1 re-asserts 1 cycle after rst falls.
  - Also: rst during FAULT clears fault.
- Early ack and boundary: in2 held high from reset -> S2 lasts exactly 1 cycle.
  - in1 arriving on the cycle the counter reaches TIMEOUT-1 -> advances, no fault.
